// File: rtl/gshare_predictor.sv
// Global-history branch predictor: saturating-counter table indexed by GHR or PC^GHR,
// with registered prediction, same-cycle update forwarding and a table-init walk.
module gshare_predictor #(
  parameter int PC_W  = 8,
  parameter int GHR_W = 4,
  parameter int IDX_W = 4,
  parameter int CTR_W = 2,
  parameter int MODE  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  output logic             ready,
  input  logic             pred_valid,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_out_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_index,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             upd_taken
);

  localparam logic [0:0]       ST_INIT   = 1'b0;
  localparam logic [0:0]       ST_RUN    = 1'b1;
  localparam int               DEPTH     = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT  = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CTR_MAX   = '1;
  localparam logic [IDX_W-1:0] WALK_LAST = '1;

  logic [CTR_W-1:0] ctr_q [DEPTH];

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] walk_q, walk_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic             pred_out_valid_q, pred_out_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic [IDX_W-1:0] pred_index_q, pred_index_d;

  logic [IDX_W-1:0] ghr_ext;
  logic [IDX_W-1:0] pred_idx;
  logic [CTR_W-1:0] upd_cur;
  logic [CTR_W-1:0] upd_new;
  logic [CTR_W-1:0] pred_ctr;
  logic             run;
  logic             do_pred;
  logic             do_upd;
  logic             unused_pc;

  assign unused_pc = ^pred_pc;

  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_W-1:0] = ghr_q;
    if (MODE == 1) pred_idx = pred_pc[IDX_W-1:0] ^ ghr_ext;
    else           pred_idx = ghr_ext;

    upd_cur = ctr_q[upd_index];
    if (upd_taken) upd_new = (upd_cur == CTR_MAX) ? upd_cur : upd_cur + CTR_W'(1);
    else           upd_new = (upd_cur == '0)      ? upd_cur : upd_cur - CTR_W'(1);

    // A same-cycle update to the predicted entry is visible to the prediction.
    if (upd_valid && (upd_index == pred_idx)) pred_ctr = upd_new;
    else                                      pred_ctr = ctr_q[pred_idx];

    run     = (state_q == ST_RUN);
    do_pred = run && pred_valid && !flush;
    do_upd  = run && upd_valid && !flush;
  end

  always_comb begin
    state_d          = state_q;
    walk_d           = walk_q;
    ghr_d            = ghr_q;
    pred_out_valid_d = do_pred;
    pred_taken_d     = pred_taken_q;
    pred_index_d     = pred_index_q;

    if (do_pred) begin
      pred_taken_d = pred_ctr[CTR_W-1];
      pred_index_d = pred_idx;
    end
    if (do_upd) ghr_d = GHR_W'({ghr_q, upd_taken});
    if (!run) begin
      walk_d = walk_q + IDX_W'(1);
      if (walk_q == WALK_LAST) state_d = ST_RUN;
    end

    if (flush) begin
      state_d          = ST_INIT;
      walk_d           = '0;
      ghr_d            = '0;
      pred_out_valid_d = 1'b0;
      pred_taken_d     = 1'b0;
      pred_index_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_INIT;
      walk_q           <= '0;
      ghr_q            <= '0;
      pred_out_valid_q <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_index_q     <= '0;
    end else begin
      state_q          <= state_d;
      walk_q           <= walk_d;
      ghr_q            <= ghr_d;
      pred_out_valid_q <= pred_out_valid_d;
      pred_taken_q     <= pred_taken_d;
      pred_index_q     <= pred_index_d;
    end
  end

  // Counter table has no reset; the init walk rewrites every entry instead.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (!run)        ctr_q[walk_q]    <= CTR_INIT;
      else if (do_upd) ctr_q[upd_index] <= upd_new;
    end
  end

  assign ready          = run;
  assign pred_out_valid = pred_out_valid_q;
  assign pred_taken     = pred_taken_q;
  assign pred_index     = pred_index_q;

endmodule
